// File: rtl/sequence_event_reporter_pkg.sv
// +----------------------------------------------------------------------------
// | sequence_event_reporter_pkg : shared defaults, FSM encodings and helpers
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package sequence_event_reporter_pkg;

  localparam int DEFAULT_W     = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_RELEASE = 2'd2
  } hs_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sequence_event_reporter_if.sv
// +----------------------------------------------------------------------------
// | sequence_event_reporter_if : dav_/rfd four-phase handshake with timestamp
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface sequence_event_reporter_if
  import sequence_event_reporter_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();

  logic         rfd;
  logic         dav_;
  logic [W-1:0] ts;

  modport master (input rfd, output dav_, output ts);
  modport slave  (output rfd, input dav_, input ts);

endinterface

`default_nettype wire

// File: rtl/sequence_event_reporter_event_fifo.sv
// +----------------------------------------------------------------------------
// | event_fifo : timestamp FIFO, extra pointer bit separates full from empty
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign head  = r_mem[r_rptr[AW-1:0]];

  // A pop at the same edge frees the head slot, so a push is still legal when full.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/sequence_event_reporter.sv
// +----------------------------------------------------------------------------
// | sequence_event_reporter : timestamps detector pulses, delivers via dav_/rfd
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module sequence_event_reporter
  import sequence_event_reporter_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset_,
  input  logic                        z,
  sequence_event_reporter_if.master   hs,
  output logic [7:0]                  count,
  output logic                        ovf
);

  hs_state_e    r_state;
  hs_state_e    w_state_nxt;
  logic [W-1:0] r_tmr;
  logic [W-1:0] r_ts;
  logic         r_dav_;
  logic         w_pop;
  logic         w_load_ts;
  logic [W-1:0] w_head;
  logic         w_full;
  logic         w_empty;

  event_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_ (reset_),
    .push   (z),
    .pop    (w_pop),
    .din    (r_tmr),
    .head   (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign hs.dav_ = r_dav_;
  assign hs.ts   = r_ts;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_ts   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && hs.rfd) begin
          w_load_ts   = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // The entry stays queued until the consumer acknowledges by dropping rfd.
        if (!hs.rfd) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (hs.rfd) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
      r_dav_  <= 1'b1;
      r_ts    <= '0;
      r_tmr   <= '0;
      count   <= 8'd0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dav_  <= (w_state_nxt != ST_OFFER);
      r_tmr   <= r_tmr + W'(1);
      if (w_load_ts) r_ts <= w_head;
      if (z) count <= sat_inc8(count);
      if (z && w_full && !w_pop) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sequence_event_reporter.sv
// +----------------------------------------------------------------------------
// | tb_sequence_event_reporter : scoreboard bench for sequence_event_reporter
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_sequence_event_reporter;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clock  = 1'b0;
  logic         reset_ = 1'b0;
  logic         z      = 1'b0;
  logic [7:0]   count;
  logic         ovf;

  sequence_event_reporter_if #(.W(W)) hs ();

  sequence_event_reporter #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clock  (clock),
    .reset_ (reset_),
    .z      (z),
    .hs     (hs.master),
    .count  (count),
    .ovf    (ovf)
  );

  always #5 clock = ~clock;

  int           tests     = 0;
  int           fails     = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cyc;
  bit           hold      = 1'b0;
  int           exp_count = 0;
  bit           wrap_seen = 1'b0;
  logic [W-1:0] last_ts   = '0;

  // Reference timer: the value a detection sampled at the next posedge must carry.
  always @(posedge clock or negedge reset_) begin
    if (!reset_) cyc <= '0;
    else         cyc <= cyc + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Consumer: raise rfd when idle, drop it once dav_ is seen low, unless held off.
  initial begin
    hs.rfd = 1'b1;
    forever begin
      @(negedge clock);
      if (hold) hs.rfd = 1'b0;
      else      hs.rfd = hs.dav_;
    end
  end

  // Monitor: every new offer pops the scoreboard; ts must stay stable while offered.
  initial begin
    logic         prev_dav;
    logic [W-1:0] held;
    logic [W-1:0] e;
    prev_dav = 1'b1;
    held     = '0;
    forever begin
      @(negedge clock);
      if (reset_ && prev_dav && !hs.dav_) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_offer: got ts=%0d, required no offer", hs.ts);
        end else begin
          e = exp_q.pop_front();
          check("offer_ts", 32'(hs.ts), 32'(e));
          if (hs.ts < last_ts) wrap_seen = 1'b1;
          last_ts = hs.ts;
        end
        held = hs.ts;
      end else if (reset_ && !prev_dav && !hs.dav_) begin
        check("ts_stable", 32'(hs.ts), 32'(held));
      end
      prev_dav = hs.dav_;
    end
  end

  task automatic do_reset(input bit h);
    hold   = h;
    reset_ = 1'b0;
    z      = 1'b0;
    exp_q.delete();
    exp_count = 0;
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic detect(input bit accept);
    @(negedge clock);
    z = 1'b1;
    if (accept) exp_q.push_back(cyc);
    if (exp_count < 255) exp_count++;
    @(negedge clock);
    z = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hs.dav_ !== 1'b1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (10) @(negedge clock);
    check(name, 32'(n < 200), 32'd1);
    check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // 1: idle after reset
    do_reset(1'b0);
    repeat (10) begin
      @(negedge clock);
      check("t1_dav", 32'(hs.dav_), 32'd1);
      check("t1_count", 32'(count), 32'd0);
      check("t1_ovf", 32'(ovf), 32'd0);
    end

    // 2: single detection at tmr=5
    do_reset(1'b0);
    n = 0;
    while (cyc != 8'd5 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t2_tmr_reach", 32'(cyc), 32'd5);
    z = 1'b1;
    exp_q.push_back(8'd5);
    exp_count = 1;
    @(negedge clock);
    z = 1'b0;
    check("t2_dav_before", 32'(hs.dav_), 32'd1);
    @(negedge clock);
    check("t2_dav_offer", 32'(hs.dav_), 32'd0);
    check("t2_ts", 32'(hs.ts), 32'd5);
    @(negedge clock);
    check("t2_dav_released", 32'(hs.dav_), 32'd1);
    check("t2_count", 32'(count), 32'd1);
    wait_drain("t2_drain");

    // 3: overflow with consumer stalled
    do_reset(1'b1);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 6; i++) detect(i < DEPTH);
    check("t3_count", 32'(count), 32'd6);
    check("t3_ovf", 32'(ovf), 32'd1);
    check("t3_dav_stalled", 32'(hs.dav_), 32'd1);
    hold = 1'b0;
    wait_drain("t3_drain");

    // 4: push coinciding with a pop while full
    do_reset(1'b1);
    repeat (2) @(negedge clock);
    for (int i = 0; i < DEPTH; i++) detect(1'b1);
    check("t4_ovf_full", 32'(ovf), 32'd0);
    hold = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (hs.dav_ !== 1'b0 && n < 20);
    check("t4_offer_seen", 32'(hs.dav_), 32'd0);
    z = 1'b1;
    exp_q.push_back(cyc);
    exp_count++;
    @(negedge clock);
    z    = 1'b0;
    hold = 1'b1;
    check("t4_ovf_after_pop_push", 32'(ovf), 32'd0);
    detect(1'b0);
    check("t4_ovf_still_full", 32'(ovf), 32'd1);
    check("t4_count", 32'(count), 32'(exp_count));
    hold = 1'b0;
    wait_drain("t4_drain");

    // 5: asynchronous reset during an offer
    do_reset(1'b1);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) detect(1'b1);
    hold = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (hs.dav_ !== 1'b0 && n < 20);
    check("t5_offer_seen", 32'(hs.dav_), 32'd0);
    #1 reset_ = 1'b0;
    #1 check("t5_dav_async", 32'(hs.dav_), 32'd1);
    exp_q.delete();
    exp_count = 0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    repeat (10) @(negedge clock);
    check("t5_dav", 32'(hs.dav_), 32'd1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_ts", 32'(hs.ts), 32'd0);

    // 6: saturation and timestamp wrap
    do_reset(1'b0);
    wrap_seen = 1'b0;
    last_ts   = '0;
    for (int i = 0; i < 300; i++) begin
      detect(1'b1);
      repeat (2) @(negedge clock);
      if (i == 253 || i == 254 || i == 299)
        check("t6_count", 32'(count), 32'(exp_count));
    end
    wait_drain("t6_drain");
    check("t6_count_sat", 32'(count), 32'd255);
    check("t6_ovf", 32'(ovf), 32'd0);
    check("t6_wrap", 32'(wrap_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
